// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the returned instruction into the IF/ID register for decode.
module fetch_unit #(
   parameter int unsigned                DATA_WIDTH    = 32,
   parameter int unsigned                ADDRESS_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0,
   parameter logic [DATA_WIDTH-1:0]      NOP_INSTR     = DATA_WIDTH'(32'h0000_0013)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_stall,
   input  logic                     i_redirect,
   input  logic [ADDRESS_WIDTH-1:0] i_redirect_target,
   output logic [ADDRESS_WIDTH-1:0] o_imem_address,
   input  logic [DATA_WIDTH-1:0]    i_imem_instruction,
   output logic [ADDRESS_WIDTH-1:0] o_id_pc,
   output logic [DATA_WIDTH-1:0]    o_id_instruction,
   output logic                     o_id_valid,
   output logic                     o_misaligned
);

   logic [ADDRESS_WIDTH-1:0] r_pc;
   logic [ADDRESS_WIDTH-1:0] r_id_pc;
   logic [DATA_WIDTH-1:0]    r_id_instruction;
   logic                     r_id_valid;
   logic                     r_misaligned;

   logic [ADDRESS_WIDTH-1:0] w_pc_seq;
   logic [ADDRESS_WIDTH-1:0] w_pc_target;
   logic                     w_target_unaligned;

   // Sequential increment wraps silently at the top of the address space.
   assign w_pc_seq           = r_pc + ADDRESS_WIDTH'(4);
   assign w_pc_target        = {i_redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
   assign w_target_unaligned = |i_redirect_target[1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc             <= RESET_VECTOR;
         r_id_pc          <= '0;
         r_id_instruction <= NOP_INSTR;
         r_id_valid       <= 1'b0;
         r_misaligned     <= 1'b0;
      end else if (i_redirect) begin
         // Redirect wins over stall; the wrong-path fetch becomes a bubble.
         r_pc             <= w_pc_target;
         r_id_pc          <= '0;
         r_id_instruction <= NOP_INSTR;
         r_id_valid       <= 1'b0;
         if (w_target_unaligned) begin
            r_misaligned <= 1'b1;
         end
      end else if (!i_stall) begin
         r_pc             <= w_pc_seq;
         r_id_pc          <= r_pc;
         r_id_instruction <= i_imem_instruction;
         r_id_valid       <= 1'b1;
      end
   end

   assign o_imem_address   = r_pc;
   assign o_id_pc          = r_id_pc;
   assign o_id_instruction = r_id_instruction;
   assign o_id_valid       = r_id_valid;
   assign o_misaligned     = r_misaligned;

endmodule
